// File: rtl/fir_datapath.sv
// ---------------------------------------------------------------------------
// fir_datapath
//
// Execution end of the FIR controller's command interface. Every clock is a
// command slot: one op/src1/src2/dest command is executed on a 16-entry
// register file through an add/sub/fixed-point-multiply ALU. Register 0 is
// the display/accumulator and drives outreg_data.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset (clears all registers
//                     and the sticky overflow flag)
//   op[2:0]      in   command opcode (NoOp/Copy/Load1/Load2/Add/Sub/Mul/rsvd)
//   src1[3:0]    in   first source register index
//   src2[3:0]    in   second source register index
//   dest[3:0]    in   destination register index
//   ext_data1    in   new sample, written by Load1
//   ext_data2    in   new coefficient, written by Load2
//   overflow     out  combinational overflow of the current Add/Sub/Mul
//   outreg_data  out  contents of register 0 (registered)
//   ovf_sticky   out  set on any committed overflow, held until reset
//
// Build option:
//   SATURATE_EN  when defined, overflowing Add/Sub/Mul results are clamped
//                to the signed DATA_W limits before writeback; otherwise the
//                wrapped low DATA_W bits are written. overflow is reported
//                identically in both builds.
// ---------------------------------------------------------------------------
module fir_datapath #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        op,
  input  logic [3:0]        src1,
  input  logic [3:0]        src2,
  input  logic [3:0]        dest,
  input  logic [DATA_W-1:0] ext_data1,
  input  logic [DATA_W-1:0] ext_data2,
  output logic              overflow,
  output logic [DATA_W-1:0] outreg_data,
  output logic              ovf_sticky
);

  localparam int NUM_REGS = 16;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_COPY  = 3'b001,
    OP_LOAD1 = 3'b010,
    OP_LOAD2 = 3'b011,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_MUL   = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  // Signed DATA_W limits used when clamping an overflowing result.
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic              ovf_sticky_q;

  // -------------------------------------------------------------------------
  // Operand fetch: combinational reads of the pre-write register contents,
  // so dest == src1/src2 naturally uses the old value.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] opa, opb;

  assign opa = rf_q[src1];
  assign opb = rf_q[src2];

  // -------------------------------------------------------------------------
  // Arithmetic
  // -------------------------------------------------------------------------
  // Add/Sub are done one bit wider; the result fits DATA_W exactly when the
  // top two bits of the extended value agree.
  logic [DATA_W:0] add_ext, sub_ext;

  assign add_ext = {opa[DATA_W-1], opa} + {opb[DATA_W-1], opb};
  assign sub_ext = {opa[DATA_W-1], opa} - {opb[DATA_W-1], opb};

  // Multiply: sign-extend both operands to 2*DATA_W so the low 2*DATA_W bits
  // of the product are the exact signed product, then rescale the Q-format
  // result with an arithmetic shift.
  logic        [2*DATA_W-1:0] opa_wide, opb_wide, mul_prod;
  logic signed [2*DATA_W-1:0] mul_shift;
  logic        [DATA_W:0]     mul_top;

  assign opa_wide  = {{DATA_W{opa[DATA_W-1]}}, opa};
  assign opb_wide  = {{DATA_W{opb[DATA_W-1]}}, opb};
  assign mul_prod  = opa_wide * opb_wide;
  assign mul_shift = $signed(mul_prod) >>> FRAC_BITS;

  // The shifted value is representable only if every bit from the DATA_W-1
  // sign position upward is a copy of the sign.
  assign mul_top = mul_shift[2*DATA_W-1 -: DATA_W+1];

  // -------------------------------------------------------------------------
  // Command decode / next-state
  // -------------------------------------------------------------------------
  logic              wr_en_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              ovf_d;
  logic              neg_d;   // true sign of the exact result, for clamping

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch can be inferred.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    ovf_d     = 1'b0;
    neg_d     = 1'b0;

    unique case (op_e'(op))
      OP_COPY: begin
        wr_en_d   = 1'b1;
        wr_data_d = opa;
      end
      OP_LOAD1: begin
        wr_en_d   = 1'b1;
        wr_data_d = ext_data1;
      end
      OP_LOAD2: begin
        wr_en_d   = 1'b1;
        wr_data_d = ext_data2;
      end
      OP_ADD: begin
        wr_en_d   = 1'b1;
        wr_data_d = add_ext[DATA_W-1:0];
        ovf_d     = add_ext[DATA_W] ^ add_ext[DATA_W-1];
        neg_d     = add_ext[DATA_W];
      end
      OP_SUB: begin
        wr_en_d   = 1'b1;
        wr_data_d = sub_ext[DATA_W-1:0];
        ovf_d     = sub_ext[DATA_W] ^ sub_ext[DATA_W-1];
        neg_d     = sub_ext[DATA_W];
      end
      OP_MUL: begin
        wr_en_d   = 1'b1;
        wr_data_d = mul_shift[DATA_W-1:0];
        ovf_d     = ~((&mul_top) | ~(|mul_top));
        neg_d     = mul_shift[2*DATA_W-1];
      end
      OP_NOP, OP_RSVD: begin
        // No write, no overflow.
      end
    endcase

`ifdef SATURATE_EN
    if (ovf_d) begin
      wr_data_d = neg_d ? MAX_NEG : MAX_POS;
    end
`else
    // Wrapped low bits are written as-is; the clamp limits stay unused.
    if (ovf_d && (neg_d ? (wr_data_d == MAX_NEG) : (wr_data_d == MAX_POS))) begin
      wr_data_d = wr_data_d;
    end
`endif
  end

  // Reported overflow is forced low during reset; it never looks at dest.
  assign overflow = ovf_d & ~reset;

  // -------------------------------------------------------------------------
  // Register file and sticky flag
  // -------------------------------------------------------------------------
  // NOTE: the register file is a small flop array whose reset contents are
  // architecturally visible (register 0 feeds outreg_data), so every entry is
  // cleared explicitly rather than left to power-up state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
      ovf_sticky_q <= 1'b0;
    end else begin
      if (wr_en_d) begin
        rf_q[dest] <= wr_data_d;
      end
      if (overflow) begin
        ovf_sticky_q <= 1'b1;
      end
    end
  end

  assign outreg_data = rf_q[0];
  assign ovf_sticky  = ovf_sticky_q;

endmodule
